cp0_irq_ctrl: RTL
=================

CP0_IRQ_CTRL -- requirements
Module: cp0_irq_ctrl

Interface
REQ-001 The block SHALL have parameter NUM_IRQ, default 4, meaning number of external interrupt lines (2..8).
REQ-002 The block SHALL have parameter DW, default 32, meaning CP0 register and PC width.
REQ-003 The block SHALL have parameter NEST_DEPTH, default 4, meaning EPC/ID stack depth (power of 2, >=2).
REQ-004 in_CLK  input  1  clock, all state updates on rising edge.
REQ-005 in_RST  input  1  reset, asynchronous, active-high.
REQ-006 in_irq  input  NUM_IRQ  interrupt request lines, synchronous to in_CLK; higher index = higher priority.
REQ-007 WE  input  1  CP0 register write enable.
REQ-008 rW  input  2  write address: 0 STATUS, 1 MASK, 2 EPC (read-only), 3 PENDING (write-1-to-clear).
REQ-009 W  input  DW  write data.
REQ-010 rA  input  2  read address, same map.
REQ-011 A  output  DW  combinational read data for rA.
REQ-012 in_take  input  1  pipeline accepts the current request at WB this cycle.
REQ-013 in_WB_PC  input  DW  PC of the WB-stage instruction.
REQ-014 in_eret  input  1  return-from-interrupt retiring this cycle.
REQ-015 out_req  output  1  interrupt request to pipeline.
REQ-016 out_irq_id  output  3  index of the requested line.
REQ-017 out_EPC  output  DW  top-of-stack EPC (0 when stack empty).
REQ-018 out_IE  output  1  STATUS[0], global interrupt enable.
REQ-019 out_lvl  output  $clog2(NEST_DEPTH)+1  current nesting depth.
REQ-020 out_ovf  output  1  sticky overflow flag, STATUS[1].

Function
REQ-021 Pending: pending[i] SHALL set on the cycle after in_irq[i] is sampled 0 then 1 (edge detect via one registered copy); level held high sets it once.
REQ-022 Eligible set SHALL be pending & MASK[NUM_IRQ-1:0] restricted to indices strictly greater than the ID on top of stack (all indices when stack empty).
REQ-023 out_req SHALL be combinational: IE & (eligible != 0) & (out_lvl < NEST_DEPTH); out_irq_id = highest eligible index, 0 when out_req=0.
REQ-024 Latency: in_irq rising at edge n -> pending at edge n+1 -> out_req high during cycle n+1 (one cycle).
REQ-025 On in_take with out_req=1: push {in_WB_PC+1 mod 2^DW, out_irq_id}, clear pending[out_irq_id], IE<=0, out_lvl+1.
REQ-026 in_take with out_req=0 SHALL be ignored except when stack full: then no push and out_ovf<=1.
REQ-027 On in_eret (no take): pop if out_lvl>0, IE<=1; with stack empty only IE<=1.
REQ-028 in_take and in_eret same cycle: take SHALL be processed, eret ignored.
REQ-029 STATUS write: IE<=W[0]; W[1]=1 clears out_ovf; suppressed for IE when a take or eret occurs same cycle (event wins).
REQ-030 MASK write SHALL always apply, including same cycle as take/eret; only low NUM_IRQ bits stored, rest read 0.
REQ-031 PENDING write: bits with W[i]=1 cleared; a new edge on the same bit in the same cycle SHALL win (bit stays set).
REQ-032 EPC write SHALL be ignored; A for rA=2 returns out_EPC; A for STATUS returns {0, ovf, IE}.

Reset
REQ-033 in_RST SHALL force IE=1, MASK=0, pending=0, edge register=0, stack empty (out_lvl=0, out_EPC=0), out_ovf=0, hence out_req=0, out_irq_id=0.
REQ-034 Reset asserted mid-nesting SHALL discard all stack entries immediately (asynchronously).

Structure
REQ-035 CP0 address constants (STATUS, MASK, EPC, PENDING) and STATUS bit positions SHALL live in shared package cp0_pkg.
REQ-036 The priority encoder with above-threshold filter SHALL be a sub-module irq_prio_enc (NUM_IRQ parameter, outputs valid + index).
REQ-037 The stack SHALL be a register array with a depth counter; no memory macro.

Verification
REQ-038 Reset, MASK=0xF, in_irq[2] 0->1 -> out_req=1, out_irq_id=2 one cycle later; in_take with in_WB_PC=0x100 -> out_EPC=0x101, IE=0, out_lvl=1, pending[2]=0.
REQ-039 Nesting: with id 2 active, IE written 1, irq[1] and irq[3] edges -> out_irq_id=3 only; take, eret -> out_EPC back to 0x101, out_lvl=1, IE=1; irq[1] still blocked until second eret.
REQ-040 Overflow: NEST_DEPTH=4, four nested takes (ids 0..3 with IE rewritten) -> out_req=0 at lvl 4; forced in_take -> out_ovf=1, lvl stays 4; STATUS write W=0x2 clears ovf.
REQ-041 Simultaneous: take+eret same cycle -> push only; PENDING W1C of bit 1 while irq[1] edge -> pending[1] stays 1; STATUS write IE=1 with take -> IE=0.
REQ-042 Reset asserted at out_lvl=3 mid-cycle -> out_lvl=0, out_EPC=0, IE=1, out_req=0 before next clock edge.
REQ-043 Wrap: in_WB_PC=0xFFFFFFFF take -> out_EPC=0x00000000; eret on empty stack -> IE=1, out_lvl=0.

Source files
------------

// File: rtl/cp0_pkg.sv
// Shared CP0 definitions for the interrupt controller slice.
// Contents:
//   cp0_addr_e     - CP0 register map used by the read and write ports
//   StatusIeBit    - STATUS bit that holds the global interrupt enable
//   StatusOvfBit   - STATUS bit that holds the sticky nesting-overflow flag
package cp0_pkg;

  typedef enum logic [1:0] {
    Cp0Status  = 2'd0,
    Cp0Mask    = 2'd1,
    Cp0Epc     = 2'd2,
    Cp0Pending = 2'd3
  } cp0_addr_e;

  localparam int unsigned StatusIeBit  = 0;
  localparam int unsigned StatusOvfBit = 1;

endpackage

// File: rtl/irq_prio_enc.sv
// Priority encoder with an above-threshold filter.
// Returns the highest set request index that is strictly greater than the
// threshold; when the threshold is not valid every index qualifies.
// Ports:
//   i_req     - request vector, higher index = higher priority
//   i_thr_vld - threshold is active
//   i_thr     - threshold index (only indices above it qualify)
//   o_valid   - at least one qualifying request
//   o_idx     - highest qualifying index, 0 when none
module irq_prio_enc #(
  parameter int unsigned NUM_IRQ = 4
) (
  input  logic [NUM_IRQ-1:0] i_req,
  input  logic               i_thr_vld,
  input  logic [2:0]         i_thr,
  output logic               o_valid,
  output logic [2:0]         o_idx
);

  always_comb begin
    o_valid = 1'b0;
    o_idx   = 3'd0;
    // Ascending scan: the last qualifying index seen is the highest one.
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      if (i_req[i] && (!i_thr_vld || (i > int'(i_thr)))) begin
        o_valid = 1'b1;
        o_idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/cp0_irq_ctrl.sv
// CP0 interrupt controller with nested-interrupt EPC/ID stack.
// Ports:
//   in_CLK, in_RST      - clock, asynchronous active-high reset
//   in_irq              - external interrupt lines (edge detected)
//   WE, rW, W           - CP0 register write port (STATUS, MASK, EPC ro, PENDING w1c)
//   rA, A               - CP0 register combinational read port
//   in_take, in_WB_PC   - pipeline accepts request; PC of the WB instruction
//   in_eret             - return-from-interrupt retiring
//   out_req, out_irq_id - request to pipeline and its line index
//   out_EPC             - top-of-stack return PC (0 when empty)
//   out_IE, out_ovf     - STATUS bits
//   out_lvl             - current nesting depth
module cp0_irq_ctrl
  import cp0_pkg::*;
#(
  parameter int unsigned NUM_IRQ    = 4,
  parameter int unsigned DW         = 32,
  parameter int unsigned NEST_DEPTH = 4
) (
  input  logic                         in_CLK,
  input  logic                         in_RST,
  input  logic [NUM_IRQ-1:0]           in_irq,
  input  logic                         WE,
  input  logic [1:0]                   rW,
  input  logic [DW-1:0]                W,
  input  logic [1:0]                   rA,
  output logic [DW-1:0]                A,
  input  logic                         in_take,
  input  logic [DW-1:0]                in_WB_PC,
  input  logic                         in_eret,
  output logic                         out_req,
  output logic [2:0]                   out_irq_id,
  output logic [DW-1:0]                out_EPC,
  output logic                         out_IE,
  output logic [$clog2(NEST_DEPTH):0]  out_lvl,
  output logic                         out_ovf
);

  localparam int unsigned PW = $clog2(NEST_DEPTH);
  localparam int unsigned LW = PW + 1;
  localparam logic [LW-1:0] FullLvl = LW'(NEST_DEPTH);

  logic [NUM_IRQ-1:0] r_irq_q;
  logic [NUM_IRQ-1:0] r_pend_q;
  logic [NUM_IRQ-1:0] r_mask_q;
  logic               r_ie_q;
  logic               r_ovf_q;
  logic [LW-1:0]      r_lvl_q;
  logic [DW-1:0]      r_epc_q [NEST_DEPTH];
  logic [2:0]         r_id_q  [NEST_DEPTH];

  logic [NUM_IRQ-1:0] w_edge;
  logic [NUM_IRQ-1:0] w_pend_d;
  logic               w_ie_d;
  logic               w_ovf_d;
  logic [PW-1:0]      w_top_idx;
  logic [2:0]         w_top_id;
  logic               w_stack_empty;
  logic               w_stack_full;
  logic               w_enc_vld;
  logic [2:0]         w_enc_idx;
  logic               w_push;
  logic               w_ovf_set;
  logic               w_eret;
  logic               w_pop;
  logic               w_st_wr;
  logic               w_msk_wr;
  logic               w_pnd_wr;
  logic               w_unused_w;

  assign w_unused_w = ^W;

  assign w_edge        = in_irq & ~r_irq_q;
  assign w_stack_empty = (r_lvl_q == '0);
  assign w_stack_full  = (r_lvl_q == FullLvl);
  // Wraps when empty; every use is gated by w_stack_empty.
  assign w_top_idx     = PW'(r_lvl_q - LW'(1));
  assign w_top_id      = r_id_q[w_top_idx];

  irq_prio_enc #(
    .NUM_IRQ (NUM_IRQ)
  ) u_prio_enc (
    .i_req     (r_pend_q & r_mask_q),
    .i_thr_vld (!w_stack_empty),
    .i_thr     (w_top_id),
    .o_valid   (w_enc_vld),
    .o_idx     (w_enc_idx)
  );

  assign out_req    = r_ie_q & w_enc_vld & (r_lvl_q < FullLvl);
  assign out_irq_id = out_req ? w_enc_idx : 3'd0;
  assign out_EPC    = w_stack_empty ? '0 : r_epc_q[w_top_idx];
  assign out_IE     = r_ie_q;
  assign out_ovf    = r_ovf_q;
  assign out_lvl    = r_lvl_q;

  assign w_push    = in_take & out_req;
  assign w_ovf_set = in_take & ~out_req & w_stack_full;
  // A take in the same cycle always shadows an eret.
  assign w_eret    = in_eret & ~in_take;
  assign w_pop     = w_eret & ~w_stack_empty;

  assign w_st_wr  = WE && (rW == Cp0Status);
  assign w_msk_wr = WE && (rW == Cp0Mask);
  assign w_pnd_wr = WE && (rW == Cp0Pending);

  always_comb begin
    w_pend_d = r_pend_q;
    if (w_pnd_wr) begin
      w_pend_d = w_pend_d & ~W[NUM_IRQ-1:0];
    end
    for (int i = 0; i < int'(NUM_IRQ); i++) begin
      if (w_push && (w_enc_idx == 3'(i))) begin
        w_pend_d[i] = 1'b0;
      end
    end
    // A fresh edge beats any clear in the same cycle.
    w_pend_d = w_pend_d | w_edge;
  end

  always_comb begin
    w_ie_d = r_ie_q;
    if (w_push) begin
      w_ie_d = 1'b0;
    end else if (w_eret) begin
      w_ie_d = 1'b1;
    end else if (w_st_wr) begin
      w_ie_d = W[StatusIeBit];
    end
    w_ovf_d = r_ovf_q;
    if (w_st_wr && W[StatusOvfBit]) begin
      w_ovf_d = 1'b0;
    end
    if (w_ovf_set) begin
      w_ovf_d = 1'b1;
    end
  end

  always_comb begin
    A = '0;
    unique case (cp0_addr_e'(rA))
      Cp0Status: begin
        A[StatusIeBit]  = r_ie_q;
        A[StatusOvfBit] = r_ovf_q;
      end
      Cp0Mask:    A[NUM_IRQ-1:0] = r_mask_q;
      Cp0Epc:     A = out_EPC;
      Cp0Pending: A[NUM_IRQ-1:0] = r_pend_q;
      default:    A = '0;
    endcase
  end

  always_ff @(posedge in_CLK or posedge in_RST) begin
    if (in_RST) begin
      r_irq_q  <= '0;
      r_pend_q <= '0;
      r_mask_q <= '0;
      r_ie_q   <= 1'b1;
      r_ovf_q  <= 1'b0;
      r_lvl_q  <= '0;
      for (int i = 0; i < int'(NEST_DEPTH); i++) begin
        r_epc_q[i] <= '0;
        r_id_q[i]  <= '0;
      end
    end else begin
      r_irq_q  <= in_irq;
      r_pend_q <= w_pend_d;
      r_ie_q   <= w_ie_d;
      r_ovf_q  <= w_ovf_d;
      if (w_msk_wr) begin
        r_mask_q <= W[NUM_IRQ-1:0];
      end
      if (w_push) begin
        r_epc_q[r_lvl_q[PW-1:0]] <= in_WB_PC + DW'(1);
        r_id_q[r_lvl_q[PW-1:0]]  <= w_enc_idx;
        r_lvl_q                  <= r_lvl_q + LW'(1);
      end else if (w_pop) begin
        r_lvl_q <= r_lvl_q - LW'(1);
      end
    end
  end

endmodule
